// File: rtl/const_lut.sv
// const_lut: runtime-programmable constant lookup table.
//   Software loads constants through the write port while the table is in
//   PROGRAM; asserting lock moves it to RUN. RUN is left only by Reset.
//   Reads have one cycle of registered latency and are fully pipelined.
//   Unwritten or out-of-range reads return DEFAULT and raise rd_miss.
// Ports:
//   Clk      : clock, all state updates on the rising edge
//   Reset    : synchronous active-high reset
//   wr_en    : write request (wr_index, wr_data)
//   lock     : request PROGRAM->RUN
//   rd_en    : read request (rd_index)
//   rd_data  : registered read value
//   rd_valid : one-cycle pulse per accepted read
//   rd_miss  : read hit an unwritten or out-of-range entry
//   locked   : high in RUN
//   wr_err   : one-cycle pulse for a rejected write
//   count    : number of valid entries
module const_lut #(
  parameter int                INDEX_W = 5,
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 32,
  parameter logic [DATA_W-1:0] DEFAULT = {DATA_W{1'b1}}
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr_en,
  input  logic [INDEX_W-1:0]         wr_index,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       lock,
  input  logic                       rd_en,
  input  logic [INDEX_W-1:0]         rd_index,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       rd_miss,
  output logic                       locked,
  output logic                       wr_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_PROGRAM = 1'b0,
    ST_RUN     = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_miss_q, rd_miss_d;
  logic               wr_err_q, wr_err_d;

  logic               wr_in_range_s;
  logic               wr_accept_s;
  logic               rd_hit_s;
  logic [DATA_W-1:0]  rd_word_s;

  // Write acceptance: only in PROGRAM and only for an existing entry.
  always_comb begin
    wr_in_range_s = (32'(wr_index) < 32'(DEPTH));
    wr_accept_s   = wr_en && (state_q == ST_PROGRAM) && wr_in_range_s;
  end

  // Read lookup; the same-cycle bypass takes priority over stored contents
  // so a write is visible to a read issued in the same cycle.
  always_comb begin
    rd_hit_s  = 1'b0;
    rd_word_s = DEFAULT;
    for (int i = 0; i < DEPTH; i++) begin
      if ((rd_index == INDEX_W'(i)) && valid_q[i]) begin
        rd_hit_s  = 1'b1;
        rd_word_s = mem_q[i];
      end
    end
    if (wr_accept_s && (wr_index == rd_index)) begin
      rd_hit_s  = 1'b1;
      rd_word_s = wr_data;
    end else begin
      rd_hit_s  = rd_hit_s;
    end
  end

  // Next-state logic: FSM, storage, count and output registers.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    valid_d    = valid_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_miss_d  = rd_miss_q;
    rd_valid_d = rd_en;
    wr_err_d   = wr_en && !wr_accept_s;

    case (state_q)
      ST_PROGRAM: state_d = lock ? ST_RUN : ST_PROGRAM;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_PROGRAM;
    endcase

    if (wr_accept_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_index == INDEX_W'(i)) begin
          mem_d[i]   = wr_data;
          valid_d[i] = 1'b1;
          // Overwrites keep the count; saturate defensively at DEPTH.
          if (!valid_q[i] && (count_q != CNT_W'(DEPTH))) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = count_d;
          end
        end
      end
    end else begin
      count_d = count_q;
    end

    // With no read, data and miss hold their previous values.
    if (rd_en) begin
      rd_data_d = rd_hit_s ? rd_word_s : DEFAULT;
      rd_miss_d = !rd_hit_s;
    end else begin
      rd_data_d = rd_data_q;
      rd_miss_d = rd_miss_q;
    end
  end

  // State registers with synchronous reset that dominates every input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_PROGRAM;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DEFAULT;
      end
      valid_q    <= '0;
      count_q    <= '0;
      rd_data_q  <= DEFAULT;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_miss_q  <= rd_miss_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_miss  = rd_miss_q;
  assign locked   = (state_q == ST_RUN);
  assign wr_err   = wr_err_q;
  assign count    = count_q;

endmodule

// File: tb/tb_const_lut.sv
// Directed testbench for const_lut with a read scoreboard: expected
// {miss, data} pairs are queued when a read is issued and popped when the
// DUT presents rd_valid.
module tb_const_lut;

  localparam int INDEX_W = 5;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] DEF = 8'd255;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [DATA_W-1:0]  wr_data;
  logic               lock;
  logic               rd_en;
  logic [INDEX_W-1:0] rd_index;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               rd_miss;
  logic               locked;
  logic               wr_err;
  logic [CNT_W-1:0]   count;

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] sb_q[$];

  const_lut #(
    .INDEX_W(INDEX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DEFAULT(DEF)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (wr_en),
    .wr_index(wr_index),
    .wr_data (wr_data),
    .lock    (lock),
    .rd_en   (rd_en),
    .rd_index(rd_index),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_miss (rd_miss),
    .locked  (locked),
    .wr_err  (wr_err),
    .count   (count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int idx, input int val);
    wr_en    = 1'b1;
    wr_index = INDEX_W'(idx);
    wr_data  = DATA_W'(val);
  endtask

  task automatic do_read(input int idx, input int exp_data, input logic exp_miss);
    rd_en    = 1'b1;
    rd_index = INDEX_W'(idx);
    sb_q.push_back({exp_miss, DATA_W'(exp_data)});
  endtask

  // Advance one clock, then check the read pipeline and the wr_err pulse.
  task automatic tick(input logic exp_werr);
    logic            rv_exp;
    logic [DATA_W:0] e;
    rv_exp = rd_en && !Reset;
    @(posedge Clk);
    @(negedge Clk);
    check("rd_valid", 32'(rd_valid), 32'(rv_exp));
    check("wr_err", 32'(wr_err), 32'(exp_werr));
    if (rv_exp && rd_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e[DATA_W-1:0]));
        check("rd_miss", 32'(rd_miss), 32'(e[DATA_W]));
      end
    end
    Reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    lock  = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; wr_en = 1'b0; wr_index = '0; wr_data = '0;
    lock = 1'b0; rd_en = 1'b0; rd_index = '0;

    // Reset state
    tick(1'b0);
    check("rst_rd_data", 32'(rd_data), 32'd255);
    check("rst_rd_miss", 32'(rd_miss), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // Unwritten entry misses
    do_read(3, 255, 1'b1); tick(1'b0);
    check("count0", 32'(count), 32'd0);
    check("locked0", 32'(locked), 32'd0);

    // Program three entries, read back-to-back
    do_write(2, 1);  tick(1'b0);
    do_write(3, 9);  tick(1'b0);
    do_write(4, 10); tick(1'b0);
    check("count3", 32'(count), 32'd3);
    do_read(2, 1, 1'b0);  tick(1'b0);
    do_read(3, 9, 1'b0);  tick(1'b0);
    do_read(4, 10, 1'b0); tick(1'b0);

    // Hold behaviour when rd_en=0
    tick(1'b0);
    check("hold_data", 32'(rd_data), 32'd10);
    check("hold_miss", 32'(rd_miss), 32'd0);

    // Overwrite keeps count
    do_write(3, 26); tick(1'b0);
    check("count_overwrite", 32'(count), 32'd3);
    do_read(3, 26, 1'b0); tick(1'b0);

    // Same-cycle bypass
    do_write(5, 54); do_read(5, 54, 1'b0); tick(1'b0);
    check("count4", 32'(count), 32'd4);

    // Out-of-range write rejected, single-cycle wr_err pulse
    do_write(20, 7); tick(1'b1);
    check("count_oor", 32'(count), 32'd4);
    tick(1'b0);
    do_read(20, 255, 1'b1); tick(1'b0);

    // Boundary: last entry accepted, DEPTH rejected
    do_write(15, 77); tick(1'b0);
    do_write(16, 88); tick(1'b1);
    do_read(15, 77, 1'b0); tick(1'b0);
    do_read(16, 255, 1'b1); tick(1'b0);
    do_read(7, 255, 1'b1); tick(1'b0);
    check("count5", 32'(count), 32'd5);

    // Lock together with a write: write lands, locked next cycle
    lock = 1'b1; do_write(6, 61); tick(1'b0);
    check("locked1", 32'(locked), 32'd1);
    check("count6", 32'(count), 32'd6);
    do_read(6, 61, 1'b0); tick(1'b0);

    // Write in RUN rejected; no bypass for a rejected write
    do_write(6, 0); do_read(6, 61, 1'b0); tick(1'b1);
    do_read(6, 61, 1'b0); tick(1'b0);
    lock = 1'b1; tick(1'b0);
    check("locked_hold", 32'(locked), 32'd1);

    // Reset mid-RUN dominates simultaneous write/lock/read
    Reset = 1'b1; wr_en = 1'b1; wr_index = 5'd6; wr_data = 8'd99;
    lock = 1'b1; rd_en = 1'b1; rd_index = 5'd6;
    tick(1'b0);
    check("rst2_locked", 32'(locked), 32'd0);
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_rd_data", 32'(rd_data), 32'd255);
    check("rst2_rd_miss", 32'(rd_miss), 32'd0);
    do_read(6, 255, 1'b1); tick(1'b0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/const_lut.md
# const_lut

Parametrised, runtime-programmable constant lookup table for the single-cycle processor: software/testbench loads constants (tap patterns, loop bounds, offsets) through a write port during a PROGRAM phase, then locks the table for RUN, where the datapath reads constants by index with one-cycle registered latency. Unwritten or out-of-range indices return a fixed error value and raise a miss flag. The block replaces a hard-coded constant table, so constant sets change without re-synthesis.

## Interface
Parameters:
- INDEX_W, 5, index width
- DATA_W, 8, constant width
- DEPTH, 32, number of entries; legal range 1..2**INDEX_W
- DEFAULT, 8'd255 (all ones, DATA_W bits), value returned on miss and reset value of every entry

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_index  in  INDEX_W  write index
- wr_data  in  DATA_W  write value
- lock  in  1  request PROGRAM->RUN transition
- rd_en  in  1  read request
- rd_index  in  INDEX_W  read index
- rd_data  out  DATA_W  registered read value
- rd_valid  out  1  rd_data/rd_miss qualify; pulses one cycle per accepted read
- rd_miss  out  1  read hit unwritten or out-of-range entry
- locked  out  1  high in RUN
- wr_err  out  1  one-cycle pulse: rejected write
- count  out  $clog2(DEPTH+1)  number of written (valid) entries

## Operation
- Storage: DEPTH x DATA_W registers plus DEPTH valid bits.
- FSM, two states: PROGRAM (after reset), RUN. PROGRAM->RUN when lock=1; RUN is left only by Reset. locked = (state==RUN).
- Write accepted iff state==PROGRAM, wr_en=1, wr_index<DEPTH: entry<=wr_data, valid<=1; count increments only if entry was previously invalid (overwrite keeps count).
- Write rejected (wr_en=1 and state==RUN, or wr_index>=DEPTH): storage unchanged, wr_err=1 next cycle.
- Read (rd_en=1, any state): next cycle rd_valid=1; if rd_index<DEPTH and entry valid: rd_data=entry, rd_miss=0; else rd_data=DEFAULT, rd_miss=1.
- Bypass: accepted write and read to same index in same cycle -> read returns wr_data, rd_miss=0.
- rd_en=0: rd_valid=0; rd_data and rd_miss hold previous values.
- count never exceeds DEPTH; no wrap.

## Timing
- Reset (sampled high at edge): all entries=DEFAULT, valid bits=0, state=PROGRAM; outputs next cycle: rd_data=DEFAULT, rd_valid=0, rd_miss=0, locked=0, wr_err=0, count=0.
- Reset dominates every other input in the same cycle, including mid-RUN and simultaneous write/lock/read; no read issued that cycle completes.
- Read latency: 1 cycle, fully pipelined (one read per cycle, back-to-back).
- Write visible to a read issued the same cycle (bypass) and every later cycle.
- lock and accepted write in same cycle: write lands (evaluated in PROGRAM); locked=1 next cycle. Write in the first RUN cycle is rejected.
- lock while already RUN: no effect.
- wr_err and rd_valid are single-cycle pulses, never stretched.

## Test plan
Config INDEX_W=5, DATA_W=8, DEPTH=16, DEFAULT=255.
- Reset, then read index 3 -> next cycle rd_valid=1, rd_data=255, rd_miss=1, count=0, locked=0.
- Write idx2=1, idx3=9, idx4=10, then reads 2,3,4 back-to-back -> rd_data 1,9,10 on consecutive cycles, rd_miss=0, count=3; rewrite idx3=26 -> count stays 3, read 3 returns 26.
- Same-cycle write idx5=54 and read idx5 -> next cycle rd_data=54, rd_miss=0; write idx20 -> wr_err pulse, count unchanged; read idx20 -> 255, rd_miss=1.
- lock with write idx6=61 same cycle -> locked=1 next cycle, read 6 returns 61; subsequent write idx6=0 -> wr_err pulse, read 6 still 61.
- Reset asserted in RUN with rd_en=1, wr_en=1 -> next cycle locked=0, count=0, rd_valid=0; read 6 -> 255, rd_miss=1.
